// File: rtl/skeleton_frame_scheduler_pkg.sv
// Shared types and width helpers for the skeleton frame scheduler slice.
package skel_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StFeed     = 3'd1,
    StWaitBusy = 3'd2,
    StProcess  = 3'd3,
    StAbort    = 3'd4
  } skel_sched_state_t;

  localparam int unsigned PIXELS_PER_FRAME = 320 * 180;

  // At least one bit so degenerate counts still give a legal vector.
  function automatic int unsigned clog2w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned hwidth(input int unsigned horizontal_count);
    return clog2w(horizontal_count);
  endfunction

  function automatic int unsigned vwidth(input int unsigned vertical_count);
    return clog2w(vertical_count);
  endfunction

  function automatic int unsigned pixels_per_frame(input int unsigned h, input int unsigned v);
    return h * v;
  endfunction

endpackage

// File: rtl/skeleton_frame_scheduler_if.sv
// Mask-stream, skeletonizer and status signals of the frame scheduler.
interface skeleton_frame_scheduler_if #(
  parameter int unsigned HWIDTH = skel_pkg::hwidth(320),
  parameter int unsigned VWIDTH = skel_pkg::vwidth(180)
);
  logic [HWIDTH-1:0] hcount_in;
  logic [VWIDTH-1:0] vcount_in;
  logic              pixel_in;
  logic              pixel_valid_in;
  logic              skel_busy_in;
  logic [HWIDTH-1:0] skel_x_com_in;
  logic [VWIDTH-1:0] skel_y_com_in;
  logic              skel_com_valid_in;
  logic [HWIDTH-1:0] skel_hcount_out;
  logic [VWIDTH-1:0] skel_vcount_out;
  logic              skel_pixel_out;
  logic              skel_valid_out;
  logic              skel_rst_out;
  logic              frame_done_out;
  logic              frame_abort_out;
  logic [15:0]       frames_dropped_out;
  logic [7:0]        passes_out;
  logic [HWIDTH-1:0] x_com_out;
  logic [VWIDTH-1:0] y_com_out;
  logic              com_valid_out;
  logic [2:0]        state_out;

  modport master (
    input  hcount_in, vcount_in, pixel_in, pixel_valid_in, skel_busy_in,
           skel_x_com_in, skel_y_com_in, skel_com_valid_in,
    output skel_hcount_out, skel_vcount_out, skel_pixel_out, skel_valid_out, skel_rst_out,
           frame_done_out, frame_abort_out, frames_dropped_out, passes_out,
           x_com_out, y_com_out, com_valid_out, state_out
  );

  modport slave (
    output hcount_in, vcount_in, pixel_in, pixel_valid_in, skel_busy_in,
           skel_x_com_in, skel_y_com_in, skel_com_valid_in,
    input  skel_hcount_out, skel_vcount_out, skel_pixel_out, skel_valid_out, skel_rst_out,
           frame_done_out, frame_abort_out, frames_dropped_out, passes_out,
           x_com_out, y_com_out, com_valid_out, state_out
  );

endinterface

// File: rtl/skeleton_frame_scheduler_frame_watchdog.sv
// Counts busy cycles while thinning and turns each frame's worth into one pass.
module frame_watchdog
  import skel_pkg::*;
#(
  parameter int unsigned PIXELS     = PIXELS_PER_FRAME,
  parameter int unsigned MAX_PASSES = 32
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       clear_in,
  input  logic       count_in,
  output logic       pass_limit_out,
  output logic [7:0] passes_out
);

  localparam int unsigned CW = clog2w(PIXELS);

  logic [CW-1:0] cycle_q;
  logic [7:0]    pass_q;

  always_ff @(posedge clk_in) begin
    if (rst_in || clear_in) begin
      cycle_q <= '0;
      pass_q  <= '0;
    end else if (count_in) begin
      if (cycle_q == CW'(PIXELS - 1)) begin
        cycle_q <= '0;
        if (pass_q != 8'hFF) pass_q <= pass_q + 8'd1;
      end else begin
        cycle_q <= cycle_q + CW'(1);
      end
    end
  end

  assign pass_limit_out = (pass_q >= 8'(MAX_PASSES));
  assign passes_out     = pass_q;

endmodule

// File: rtl/skeleton_frame_scheduler.sv
// Admits whole aligned frames into an idle skeletonizer, bounds thinning time and latches CoM.
module skeleton_frame_scheduler
  import skel_pkg::*;
#(
  parameter int unsigned HORIZONTAL_COUNT = 320,
  parameter int unsigned VERTICAL_COUNT   = 180,
  parameter int unsigned MAX_PASSES       = 32,
  parameter int unsigned BUSY_TIMEOUT     = 8,
  parameter int unsigned ABORT_RST_CYCLES = 4
) (
  input logic clk_in,
  input logic rst_in,
  skeleton_frame_scheduler_if.master bus
);

  localparam int unsigned HWIDTH = hwidth(HORIZONTAL_COUNT);
  localparam int unsigned VWIDTH = vwidth(VERTICAL_COUNT);
  localparam int unsigned PIXELS = pixels_per_frame(HORIZONTAL_COUNT, VERTICAL_COUNT);
  localparam int unsigned TW     = clog2w(BUSY_TIMEOUT);
  localparam int unsigned AW     = clog2w(ABORT_RST_CYCLES);

  localparam logic [HWIDTH-1:0] H_LAST = HWIDTH'(HORIZONTAL_COUNT - 1);
  localparam logic [VWIDTH-1:0] V_LAST = VWIDTH'(VERTICAL_COUNT - 1);

  skel_sched_state_t state_q;
  logic [HWIDTH-1:0] hcount_q;
  logic [VWIDTH-1:0] vcount_q;
  logic              pixel_q;
  logic              valid_q;
  logic              skel_rst_q;
  logic              done_q;
  logic              abort_q;
  logic [15:0]       dropped_q;
  logic [7:0]        passes_q;
  logic [HWIDTH-1:0] x_com_q;
  logic [VWIDTH-1:0] y_com_q;
  logic              com_valid_q;
  logic [TW-1:0]     timeout_q;
  logic [AW-1:0]     abort_cnt_q;

  logic       start_px;
  logic       last_px;
  logic       fwd;
  logic       drop;
  logic       pass_limit;
  logic [7:0] wd_passes;

  assign start_px = bus.pixel_valid_in && (bus.hcount_in == '0) && (bus.vcount_in == '0);
  assign last_px  = bus.pixel_valid_in && (bus.hcount_in == H_LAST) && (bus.vcount_in == V_LAST);
  assign fwd      = ((state_q == StFeed) && bus.pixel_valid_in) ||
                    ((state_q == StIdle) && start_px && !bus.skel_busy_in);
  assign drop     = start_px && ((state_q == StWaitBusy) || (state_q == StProcess) ||
                                 (state_q == StAbort));

  // Counters sit at zero outside PROCESS, so they are clear on every entry.
  frame_watchdog #(
    .PIXELS     (PIXELS),
    .MAX_PASSES (MAX_PASSES)
  ) u_watchdog (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .clear_in       (state_q != StProcess),
    .count_in       ((state_q == StProcess) && bus.skel_busy_in),
    .pass_limit_out (pass_limit),
    .passes_out     (wd_passes)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= StIdle;
      hcount_q    <= '0;
      vcount_q    <= '0;
      pixel_q     <= 1'b0;
      valid_q     <= 1'b0;
      skel_rst_q  <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      dropped_q   <= '0;
      passes_q    <= '0;
      x_com_q     <= '0;
      y_com_q     <= '0;
      com_valid_q <= 1'b0;
      timeout_q   <= '0;
      abort_cnt_q <= '0;
    end else begin
      valid_q <= fwd;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      if (fwd) begin
        hcount_q <= bus.hcount_in;
        vcount_q <= bus.vcount_in;
        pixel_q  <= bus.pixel_in;
      end
      if (drop && (dropped_q != 16'hFFFF)) dropped_q <= dropped_q + 16'd1;
      if (bus.skel_com_valid_in) begin
        x_com_q     <= bus.skel_x_com_in;
        y_com_q     <= bus.skel_y_com_in;
        com_valid_q <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (fwd) state_q <= StFeed;
        end
        StFeed: begin
          if (last_px) begin
            state_q   <= StWaitBusy;
            timeout_q <= '0;
          end
        end
        StWaitBusy: begin
          if (bus.skel_busy_in) begin
            state_q <= StProcess;
          end else if (timeout_q == TW'(BUSY_TIMEOUT - 1)) begin
            state_q     <= StAbort;
            skel_rst_q  <= 1'b1;
            abort_q     <= 1'b1;
            passes_q    <= wd_passes;
            abort_cnt_q <= '0;
          end else begin
            timeout_q <= timeout_q + TW'(1);
          end
        end
        StProcess: begin
          // A falling busy wins over a pass limit reached in the same cycle.
          if (!bus.skel_busy_in) begin
            state_q  <= StIdle;
            done_q   <= 1'b1;
            passes_q <= wd_passes;
          end else if (pass_limit) begin
            state_q     <= StAbort;
            skel_rst_q  <= 1'b1;
            abort_q     <= 1'b1;
            passes_q    <= wd_passes;
            abort_cnt_q <= '0;
          end
        end
        StAbort: begin
          if (abort_cnt_q == AW'(ABORT_RST_CYCLES - 1)) begin
            state_q    <= StIdle;
            skel_rst_q <= 1'b0;
          end else begin
            abort_cnt_q <= abort_cnt_q + AW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.skel_hcount_out    = hcount_q;
  assign bus.skel_vcount_out    = vcount_q;
  assign bus.skel_pixel_out     = pixel_q;
  assign bus.skel_valid_out     = valid_q;
  assign bus.skel_rst_out       = skel_rst_q | rst_in;
  assign bus.frame_done_out     = done_q;
  assign bus.frame_abort_out    = abort_q;
  assign bus.frames_dropped_out = dropped_q;
  assign bus.passes_out         = passes_q;
  assign bus.x_com_out          = x_com_q;
  assign bus.y_com_out          = y_com_q;
  assign bus.com_valid_out      = com_valid_q;
  assign bus.state_out          = state_q;

endmodule

// File: tb/tb_skeleton_frame_scheduler.sv
// Randomized bench for skeleton_frame_scheduler on a small 8x4 frame against a frame-level model.
module tb_skeleton_frame_scheduler;
  import skel_pkg::*;

  localparam int unsigned HC  = 8;
  localparam int unsigned VC  = 4;
  localparam int unsigned MP  = 4;
  localparam int unsigned BT  = 8;
  localparam int unsigned ARC = 4;
  localparam int unsigned HW  = hwidth(HC);
  localparam int unsigned VW  = vwidth(VC);
  localparam int unsigned PPF = HC * VC;

  typedef struct packed {
    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          p;
  } px_t;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;

  skeleton_frame_scheduler_if #(.HWIDTH(HW), .VWIDTH(VW)) bus ();

  skeleton_frame_scheduler #(
    .HORIZONTAL_COUNT (HC),
    .VERTICAL_COUNT   (VC),
    .MAX_PASSES       (MP),
    .BUSY_TIMEOUT     (BT),
    .ABORT_RST_CYCLES (ARC)
  ) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: expected forwarded pixels, drop count, last CoM.
  px_t           exp_q[$];
  int            m_drop      = 0;
  logic [HW-1:0] m_com_x     = '0;
  logic [VW-1:0] m_com_y     = '0;
  logic          m_com_valid = 1'b0;
  int            rst_hi_cnt  = 0;
  int            abort_seen  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (bus.skel_rst_out) rst_hi_cnt++;
      if (bus.frame_abort_out) abort_seen++;
      if (bus.skel_valid_out) begin
        if (exp_q.size() == 0) begin
          check_eq("fwd_unexpected", bus.skel_valid_out, 0);
        end else begin
          px_t e;
          e = exp_q.pop_front();
          check_eq("fwd_h", bus.skel_hcount_out, e.h);
          check_eq("fwd_v", bus.skel_vcount_out, e.v);
          check_eq("fwd_pix", bus.skel_pixel_out, e.p);
        end
      end
    end
  end

  // One clock with the given pixel; occasionally strobes a random CoM.
  task automatic drive_px(input bit v, input int h, input int y, input bit p);
    bus.pixel_valid_in = v;
    bus.hcount_in      = HW'(h);
    bus.vcount_in      = VW'(y);
    bus.pixel_in       = p;
    if ($urandom_range(7) == 0) begin
      bus.skel_com_valid_in = 1'b1;
      bus.skel_x_com_in     = HW'($urandom);
      bus.skel_y_com_in     = VW'($urandom);
      m_com_x     = bus.skel_x_com_in;
      m_com_y     = bus.skel_y_com_in;
      m_com_valid = 1'b1;
    end
    @(posedge clk_in);
    #1;
    bus.pixel_valid_in    = 1'b0;
    bus.skel_com_valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_px(0, 0, 0, 0);
  endtask

  // Raster from (sx,sy) to the frame end; accepted pixels are expected downstream.
  task automatic send_frame(input bit accept, input bit gaps, input int sx, input int sy);
    for (int y = sy; y < VC; y++) begin
      for (int x = (y == sy) ? sx : 0; x < HC; x++) begin
        bit p;
        if (gaps && $urandom_range(3) == 0) idle($urandom_range(1, 2));
        p = 1'($urandom);
        if (accept) exp_q.push_back('{h: HW'(x), v: VW'(y), p: p});
        drive_px(1, x, y, p);
      end
    end
  endtask

  task automatic check_status(input string tag);
    check_eq({tag, "_dropped"}, bus.frames_dropped_out, m_drop);
    check_eq({tag, "_com_valid"}, bus.com_valid_out, m_com_valid);
    if (m_com_valid) begin
      check_eq({tag, "_com_x"}, bus.x_com_out, m_com_x);
      check_eq({tag, "_com_y"}, bus.y_com_out, m_com_y);
    end
    check_eq({tag, "_fwd_pending"}, exp_q.size(), 0);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 20 && bus.state_out != 3'd0; i++) idle(1);
    check_eq({tag, "_reached_idle"}, bus.state_out, 0);
  endtask

  // Busy rises after `pre` idle cycles and stays high for l1 cycles of thinning.
  task automatic thin_and_finish(input string tag, input int pre, input int l1, input bit with_drop);
    idle(pre);
    bus.skel_busy_in = 1'b1;
    idle(1);
    check_eq({tag, "_process"}, bus.state_out, 3);
    if (with_drop) begin
      send_frame(0, 0, 0, 0);
      m_drop++;
      idle(l1 - PPF);
    end else begin
      idle(l1);
    end
    bus.skel_busy_in = 1'b0;
    idle(1);
    check_eq({tag, "_done_state"}, bus.state_out, 0);
    check_eq({tag, "_done_pulse"}, bus.frame_done_out, 1);
    check_eq({tag, "_passes"}, bus.passes_out, l1 / PPF);
    idle(1);
    check_eq({tag, "_done_one_cycle"}, bus.frame_done_out, 0);
    check_status(tag);
  endtask

  initial begin : sim_limit
    #1_000_000;
    $display("FAIL sim_limit: simulation still running at time %0t", $time);
    $fatal(1);
  end

  initial begin
    int l1;
    int r0;
    int a0;
    bus.pixel_valid_in    = 1'b0;
    bus.hcount_in         = '0;
    bus.vcount_in         = '0;
    bus.pixel_in          = 1'b0;
    bus.skel_busy_in      = 1'b0;
    bus.skel_x_com_in     = '0;
    bus.skel_y_com_in     = '0;
    bus.skel_com_valid_in = 1'b0;

    repeat (3) @(posedge clk_in);
    #1;
    check_eq("rst_skel_rst_held", bus.skel_rst_out, 1);
    rst_in = 1'b0;
    @(posedge clk_in);
    #1;
    check_eq("rst_state", bus.state_out, 0);
    check_eq("rst_valid", bus.skel_valid_out, 0);
    check_eq("rst_skel_rst", bus.skel_rst_out, 0);
    check_eq("rst_done", bus.frame_done_out, 0);
    check_eq("rst_abort", bus.frame_abort_out, 0);
    check_eq("rst_passes", bus.passes_out, 0);
    check_status("rst");

    // Accepted frames with random gaps and thinning lengths; run 2 also drops a frame.
    for (int run = 0; run < 4; run++) begin
      send_frame(1, run != 0, 0, 0);
      check_eq("frame_wait_busy", bus.state_out, 2);
      if (run == 0) l1 = 3 * PPF;
      else if (run == 2) l1 = PPF + int'($urandom_range(0, PPF));
      else l1 = int'($urandom_range(0, MP - 1)) * PPF + int'($urandom_range(0, PPF - 1));
      thin_and_finish("frame", int'($urandom_range(0, BT - 2)), l1, run == 2);
    end

    // Busy falls exactly as the pass limit is reached: completion wins.
    send_frame(1, 0, 0, 0);
    thin_and_finish("prio", int'($urandom_range(0, BT - 2)), MP * PPF, 0);

    // Busy stuck high: abort after MP passes.
    send_frame(1, 1, 0, 0);
    r0 = rst_hi_cnt;
    a0 = abort_seen;
    bus.skel_busy_in = 1'b1;
    idle(1);
    idle(MP * PPF);
    check_eq("wd_still_process", bus.state_out, 3);
    idle(1);
    check_eq("wd_abort_state", bus.state_out, 4);
    check_eq("wd_abort_pulse", bus.frame_abort_out, 1);
    check_eq("wd_skel_rst", bus.skel_rst_out, 1);
    check_eq("wd_passes", bus.passes_out, MP);
    wait_idle("wd");
    check_eq("wd_rst_cycles", rst_hi_cnt - r0, ARC);
    check_eq("wd_abort_pulses", abort_seen - a0, 1);
    bus.skel_busy_in = 1'b0;
    idle(2);
    check_status("wd");

    // Mid-frame start is ignored; next (0,0) is forwarded one cycle later.
    send_frame(0, 1, 5, 2);
    begin
      bit p;
      p = 1'($urandom);
      exp_q.push_back('{h: '0, v: '0, p: p});
      drive_px(1, 0, 0, p);
      check_eq("mid_first_valid", bus.skel_valid_out, 1);
      check_eq("mid_first_h", bus.skel_hcount_out, 0);
      check_eq("mid_first_v", bus.skel_vcount_out, 0);
    end
    send_frame(1, 1, 1, 0);

    // Busy never rises: abort after the timeout; a start during abort is dropped.
    r0 = rst_hi_cnt;
    idle(BT - 1);
    check_eq("to_wait_busy", bus.state_out, 2);
    idle(1);
    check_eq("to_abort_state", bus.state_out, 4);
    check_eq("to_abort_pulse", bus.frame_abort_out, 1);
    check_eq("to_passes", bus.passes_out, 0);
    drive_px(1, 0, 0, 1'($urandom));
    m_drop++;
    wait_idle("to");
    check_eq("to_rst_cycles", rst_hi_cnt - r0, ARC);
    check_status("to");
    send_frame(1, 1, 0, 0);
    l1 = int'($urandom_range(0, MP - 1)) * PPF + int'($urandom_range(0, PPF - 1));
    thin_and_finish("after_to", int'($urandom_range(0, BT - 2)), l1, 0);

    // Reset in PROCESS with a CoM strobe on the same edge.
    send_frame(1, 0, 0, 0);
    bus.skel_busy_in = 1'b1;
    idle(5);
    check_eq("rstp_process", bus.state_out, 3);
    rst_in                = 1'b1;
    bus.skel_com_valid_in = 1'b1;
    bus.skel_x_com_in     = HW'(3);
    bus.skel_y_com_in     = VW'(2);
    bus.pixel_valid_in    = 1'b1;
    bus.hcount_in         = '0;
    bus.vcount_in         = '0;
    @(posedge clk_in);
    #1;
    bus.skel_com_valid_in = 1'b0;
    bus.pixel_valid_in    = 1'b0;
    m_drop      = 0;
    m_com_valid = 1'b0;
    check_eq("rstp_state", bus.state_out, 0);
    check_eq("rstp_com_valid", bus.com_valid_out, 0);
    check_eq("rstp_valid", bus.skel_valid_out, 0);
    check_eq("rstp_dropped", bus.frames_dropped_out, 0);
    rst_in           = 1'b0;
    bus.skel_busy_in = 1'b0;
    @(posedge clk_in);
    #1;
    check_eq("rstp_skel_rst", bus.skel_rst_out, 0);
    check_eq("rstp_passes", bus.passes_out, 0);

    // A clean frame after reset is accepted again.
    send_frame(1, 1, 0, 0);
    thin_and_finish("post_rst", 1, PPF + 3, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/skeleton_frame_scheduler.md
Name: skeleton_frame_scheduler

Overview:
Sequences whole frames of the binary mask stream into the skeletonizer. The skeletonizer cannot accept pixels while it iterates, so this block admits only complete, aligned frames when the skeletonizer is idle and drops other frames with a count. It bounds thinning time with a pass-count watchdog that aborts and resets the skeletonizer, and it latches the most recent centre-of-mass result. It sits between the mask thresholding stage and the skeletonizer.

Parameters:
- HORIZONTAL_COUNT, 320, frame width in pixels
- VERTICAL_COUNT, 180, frame height in pixels
- MAX_PASSES, 32, passes allowed per frame before abort; one pass is HORIZONTAL_COUNT*VERTICAL_COUNT busy cycles
- BUSY_TIMEOUT, 8, cycles allowed between the forwarded last pixel and busy rising
- ABORT_RST_CYCLES, 4, length of the skeletonizer reset pulse on abort
- HWIDTH = $clog2(HORIZONTAL_COUNT), VWIDTH = $clog2(VERTICAL_COUNT), derived localparams

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous, active-high reset
- hcount_in  in  HWIDTH  source pixel x
- vcount_in  in  VWIDTH  source pixel y
- pixel_in  in  1  source mask bit
- pixel_valid_in  in  1  source pixel strobe
- skel_busy_in  in  1  skeletonizer busy
- skel_x_com_in  in  HWIDTH  skeletonizer CoM x
- skel_y_com_in  in  VWIDTH  skeletonizer CoM y
- skel_com_valid_in  in  1  skeletonizer CoM strobe
- skel_hcount_out  out  HWIDTH  forwarded x
- skel_vcount_out  out  VWIDTH  forwarded y
- skel_pixel_out  out  1  forwarded mask bit
- skel_valid_out  out  1  forwarded strobe
- skel_rst_out  out  1  skeletonizer reset, ORed with system reset at top level
- frame_done_out  out  1  one-cycle pulse when a frame completes normally
- frame_abort_out  out  1  one-cycle pulse on abort
- frames_dropped_out  out  16  saturating count of dropped frames
- passes_out  out  8  pass count of the last completed or aborted frame
- x_com_out  out  HWIDTH  latched CoM x
- y_com_out  out  VWIDTH  latched CoM y
- com_valid_out  out  1  high once any CoM has been latched
- state_out  out  3  current FSM state, for debug

Behaviour:
- Reset: FSM goes to IDLE. All outputs are 0, and all counters and latches clear.
- Forwarding path: a single register stage, so latency is 1 cycle. skel_valid_out = pixel_valid_in delayed one cycle, gated by the state being FEED (or IDLE on an accepted start pixel).
- FSM states: IDLE=0, FEED=1, WAIT_BUSY=2, PROCESS=3, ABORT=4.
- IDLE -> FEED on a valid pixel with h=0, v=0 while skel_busy_in=0. That pixel is forwarded. Valid pixels with h≠0 or v≠0 in IDLE are discarded silently (mid-frame start).
- FEED: forward every valid pixel. A valid pixel with h=HORIZONTAL_COUNT-1 and v=VERTICAL_COUNT-1 moves the FSM to WAIT_BUSY. A valid pixel with h=0, v=0 arriving in FEED (restart) is forwarded, and the FSM stays in FEED.
- WAIT_BUSY: skel_busy_in=1 -> PROCESS, and pass and cycle counters clear. If BUSY_TIMEOUT cycles elapse without busy -> ABORT.
- PROCESS: a cycle counter wraps at HORIZONTAL_COUNT*VERTICAL_COUNT-1 and increments the pass counter on each wrap.
  - busy falls -> IDLE, frame_done_out pulses, passes_out gets the pass count.
  - pass counter reaches MAX_PASSES while busy -> ABORT.
- ABORT: skel_rst_out is held high for ABORT_RST_CYCLES cycles, frame_abort_out pulses on entry, passes_out is updated, then the FSM returns to IDLE.
- Frame drop: a valid h=0, v=0 pixel seen in WAIT_BUSY, PROCESS or ABORT increments frames_dropped_out. The counter saturates at 0xFFFF.
- CoM latch: skel_com_valid_in captures the CoM x/y inputs and sets com_valid_out in any state. The latch and com_valid_out are cleared only by rst_in, not by abort.
- Simultaneous busy-fall and pass limit in the same cycle: done takes priority.
- rst_in mid-frame: returns to IDLE on the next edge, with skel_valid_out=0 that same cycle.

Decomposition:
- Package skel_pkg holds:
  - the state enum skel_sched_state_t
  - the PIXELS_PER_FRAME constant
  - functions returning the width localparams
- Sub-module frame_watchdog holds the cycle/pass counters and exposes the pass_limit and count outputs.

Test Plan:
1. Full 320x180 frame; model busy high for 3*57600 cycles then low -> frame_done_out pulses once, passes_out=3, frames_dropped_out=0, 57600 forwarded pixels.
2. A second frame start arrives while busy -> no skel_valid_out for that frame, frames_dropped_out=1.
3. Busy held high indefinitely -> abort after 32*57600 cycles, skel_rst_out high for exactly 4 cycles, frame_abort_out=1 for 1 cycle, passes_out=32.
4. Stream starts at pixel (100,50) -> nothing forwarded until the next (0,0); the first forwarded coordinate is (0,0) one cycle after the input.
5. Busy never rises after the last pixel -> ABORT 8 cycles later; the next frame is accepted normally.
6. rst_in asserted in PROCESS with skel_com_valid_in=1 on the same edge -> state_out=0 and com_valid_out=0 on the next cycle.
